// File: rtl/intra_xfer_engine_pkg.sv
// Shared definitions for the O-buffer to A-buffer transfer path: FSM state
// encoding, counter width helper and requantisation saturation limits.
package intra_xfer_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } xfer_state_e;

  // Width of a row/column count able to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // Counter width used by the buffer blocks for the default 16-bank array.
  localparam int CNT_W = cnt_width(16);

  // Largest and smallest signed value representable in act_width bits.
  function automatic int act_max(input int act_width);
    return (1 << (act_width - 1)) - 1;
  endfunction

  function automatic int act_min(input int act_width);
    return -(1 << (act_width - 1));
  endfunction

endpackage

// File: rtl/intra_xfer_engine_requant_lane.sv
// One requantisation lane: rounding arithmetic right shift, optional ReLU and
// saturation of a signed accumulator down to a signed activation.
module intra_xfer_engine_requant_lane
  import intra_xfer_engine_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ACT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic signed [DATA_WIDTH-1:0]  x,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  input  logic                          relu_en,
  output logic        [ACT_WIDTH-1:0]   y
);

  // One guard bit so the rounding bias can never overflow.
  localparam int XW = DATA_WIDTH + 1;
  localparam logic signed [XW-1:0] SAT_MAX = XW'(act_max(ACT_WIDTH));
  localparam logic signed [XW-1:0] SAT_MIN = XW'(act_min(ACT_WIDTH));

  int                   s;
  logic signed [XW-1:0] bias;
  logic signed [XW-1:0] t;
  logic signed [XW-1:0] q;
  logic signed [XW-1:0] r;

  // Round-half-up shift, then ReLU, then clamp into the activation range.
  always_comb begin
    s    = (int'(shift) > DATA_WIDTH - 1) ? DATA_WIDTH - 1 : int'(shift);
    bias = '0;
    if (s > 0) begin
      bias = XW'(1) << (s - 1);
    end
    t = $signed({x[DATA_WIDTH-1], x}) + bias;
    q = t >>> s;
    r = (relu_en && q[XW-1]) ? '0 : q;
    if (r > SAT_MAX) begin
      y = ACT_WIDTH'(SAT_MAX);
    end else if (r < SAT_MIN) begin
      y = ACT_WIDTH'(SAT_MIN);
    end else begin
      y = r[ACT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/intra_xfer_engine.sv
// Moves a rows x cols tile from the O buffer into the A buffer, requantising
// each lane on the way, with straight or transposed write layout and abort.
// All outputs are registered; the next-state block computes their next values.
module intra_xfer_engine
  import intra_xfer_engine_pkg::*;
#(
  parameter int ARRAY_N     = 16,
  parameter int ARRAY_M     = 16,
  parameter int ACT_WIDTH   = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int RD_LAT      = 1,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [$clog2(ARRAY_N):0]      num_rows,
  input  logic [$clog2(ARRAY_M):0]      num_cols,
  input  logic [ADDR_WIDTH-1:0]         o_base_addr,
  input  logic [ADDR_WIDTH-1:0]         a_base_addr,
  input  logic [SHIFT_WIDTH-1:0]        shift,
  input  logic                          relu_en,
  input  logic                          transpose,
  output logic                          o_rd_en,
  output logic [ADDR_WIDTH-1:0]         o_rd_addr,
  input  logic [DATA_WIDTH*ARRAY_M-1:0] o_rd_data,
  output logic [ARRAY_N-1:0]            a_wr_en,
  output logic [ADDR_WIDTH-1:0]         a_wr_addr,
  output logic [ACT_WIDTH*ARRAY_M-1:0]  a_wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int RW = cnt_width(ARRAY_N);
  localparam int CW = cnt_width(ARRAY_M);
  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int QW = ACT_WIDTH * ARRAY_M;

  xfer_state_e             state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [RW-1:0]           rows_q, rows_d;
  logic [CW-1:0]           cols_q, cols_d;
  logic [ADDR_WIDTH-1:0]   o_base_q, o_base_d;
  logic [ADDR_WIDTH-1:0]   a_base_q, a_base_d;
  logic [SHIFT_WIDTH-1:0]  shift_q, shift_d;
  logic                    relu_q, relu_d;
  logic                    tr_q, tr_d;
  logic [QW-1:0]           q_q, q_d;
  logic                    o_rd_en_q, o_rd_en_d;
  logic [ADDR_WIDTH-1:0]   o_rd_addr_q, o_rd_addr_d;
  logic [ARRAY_N-1:0]      a_wr_en_q, a_wr_en_d;
  logic [ADDR_WIDTH-1:0]   a_wr_addr_q, a_wr_addr_d;
  logic [QW-1:0]           a_wr_data_q, a_wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic [QW-1:0]           lane_y;
  logic                    cfg_bad;
  logic                    wr_emit;

  // Requantisers see the O row directly; the result is captured into q at
  // the end of the read-latency wait.
  for (genvar gi = 0; gi < ARRAY_M; gi++) begin : g_lane
    intra_xfer_engine_requant_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACT_WIDTH  (ACT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .x      (o_rd_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .shift  (shift_q),
      .relu_en(relu_q),
      .y      (lane_y[gi*ACT_WIDTH +: ACT_WIDTH])
    );
  end

  // Next state, counters, latched config and next registered outputs.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    wait_d      = wait_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    o_base_d    = o_base_q;
    a_base_d    = a_base_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    tr_d        = tr_q;
    q_d         = q_q;
    o_rd_en_d   = 1'b0;
    o_rd_addr_d = o_rd_addr_q;
    a_wr_en_d   = '0;
    a_wr_addr_d = a_wr_addr_q;
    a_wr_data_d = a_wr_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    wr_emit     = 1'b0;
    cfg_bad     = (num_rows == '0) || (num_rows > RW'(ARRAY_N)) ||
                  (num_cols == '0) || (num_cols > CW'(ARRAY_M));

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (cfg_bad) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            rows_d      = num_rows;
            cols_d      = num_cols;
            o_base_d    = o_base_addr;
            a_base_d    = a_base_addr;
            shift_d     = shift;
            relu_d      = relu_en;
            tr_d        = transpose;
            row_d       = '0;
            state_d     = ST_RD;
            o_rd_en_d   = 1'b1;
            o_rd_addr_d = o_base_addr;
          end
        end
      end
      ST_RD: begin
        state_d = ST_WAIT;
        wait_d  = '0;
      end
      ST_WAIT: begin
        if (wait_q == WW'(RD_LAT - 1)) begin
          q_d     = lane_y;
          state_d = ST_WR;
          col_d   = '0;
          wr_emit = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_WR: begin
        if (tr_q && (col_q != cols_q - CW'(1))) begin
          col_d   = col_q + CW'(1);
          wr_emit = 1'b1;
        end else if (row_q == rows_q - RW'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          row_d       = row_q + RW'(1);
          state_d     = ST_RD;
          o_rd_en_d   = 1'b1;
          o_rd_addr_d = o_base_q + ADDR_WIDTH'(row_d);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Straight: one whole-row write. Transposed: row r becomes bank r,
    // column c becomes address a_base+c.
    if (wr_emit) begin
      if (!tr_q) begin
        a_wr_addr_d = a_base_q + ADDR_WIDTH'(row_q);
        for (int i = 0; i < ARRAY_N; i++) begin
          a_wr_en_d[i] = (i < int'(cols_q));
        end
        a_wr_data_d = q_d;
      end else begin
        a_wr_addr_d = a_base_q + ADDR_WIDTH'(col_d);
        a_wr_en_d   = ARRAY_N'(1) << row_q;
        a_wr_data_d = '0;
        for (int i = 0; i < ARRAY_M; i++) begin
          if (i == int'(row_q)) begin
            a_wr_data_d[i*ACT_WIDTH +: ACT_WIDTH] = q_d[int'(col_d)*ACT_WIDTH +: ACT_WIDTH];
          end
        end
      end
    end

    // Abort overrides everything: back to idle, strobes dropped, buses held.
    if (abort) begin
      state_d     = ST_IDLE;
      o_rd_en_d   = 1'b0;
      a_wr_en_d   = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      o_rd_addr_d = o_rd_addr_q;
      a_wr_addr_d = a_wr_addr_q;
      a_wr_data_d = a_wr_data_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, config and output registers with async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      wait_q      <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      o_base_q    <= '0;
      a_base_q    <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      tr_q        <= 1'b0;
      q_q         <= '0;
      o_rd_en_q   <= 1'b0;
      o_rd_addr_q <= '0;
      a_wr_en_q   <= '0;
      a_wr_addr_q <= '0;
      a_wr_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wait_q      <= wait_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      o_base_q    <= o_base_d;
      a_base_q    <= a_base_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      tr_q        <= tr_d;
      q_q         <= q_d;
      o_rd_en_q   <= o_rd_en_d;
      o_rd_addr_q <= o_rd_addr_d;
      a_wr_en_q   <= a_wr_en_d;
      a_wr_addr_q <= a_wr_addr_d;
      a_wr_data_q <= a_wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_rd_en   = o_rd_en_q;
  assign o_rd_addr = o_rd_addr_q;
  assign a_wr_en   = a_wr_en_q;
  assign a_wr_addr = a_wr_addr_q;
  assign a_wr_data = a_wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_intra_xfer_engine.sv
// Scoreboard bench for intra_xfer_engine: a reference model expands each
// transfer into the ordered read/write/done events it must produce, and a
// monitor compares every DUT event against the head of that queue.
module tb_intra_xfer_engine;

  localparam int N = 16, M = 16, AW = 8, DW = 32, ADW = 10, RD_LAT = 3, SW = 5;

  logic             clk = 1'b0;
  logic             reset, start, abort;
  logic [4:0]       num_rows, num_cols;
  logic [ADW-1:0]   o_base_addr, a_base_addr;
  logic [SW-1:0]    shift;
  logic             relu_en, transpose;
  logic             o_rd_en;
  logic [ADW-1:0]   o_rd_addr;
  logic [DW*M-1:0]  o_rd_data;
  logic [N-1:0]     a_wr_en;
  logic [ADW-1:0]   a_wr_addr;
  logic [AW*M-1:0]  a_wr_data;
  logic             busy, done, err;

  always #5 clk = ~clk;

  intra_xfer_engine #(
    .ARRAY_N(N), .ARRAY_M(M), .ACT_WIDTH(AW), .DATA_WIDTH(DW),
    .ADDR_WIDTH(ADW), .RD_LAT(RD_LAT), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_rows(num_rows), .num_cols(num_cols),
    .o_base_addr(o_base_addr), .a_base_addr(a_base_addr),
    .shift(shift), .relu_en(relu_en), .transpose(transpose),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
    .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  // O buffer: data is valid exactly RD_LAT cycles after a read, junk otherwise.
  logic [DW*M-1:0] o_mem [0:1023];
  logic [RD_LAT-1:0] pv = '0;
  logic [ADW-1:0]    pa [RD_LAT];
  logic [DW*M-1:0]   junk = '0;
  always @(posedge clk) begin
    pv[0] <= o_rd_en;
    pa[0] <= o_rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    for (int i = 0; i < M; i++) junk[i*DW +: DW] <= $urandom();
  end
  assign o_rd_data = pv[RD_LAT-1] ? o_mem[pa[RD_LAT-1]] : junk;

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 done
    logic [9:0]  addr;
    logic [15:0] en;
    logic [127:0] data;
    bit          err;
  } ev_t;

  ev_t          exp_q[$];
  logic [127:0] wr_log[$];
  int           errors = 0;
  int           checks = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requantisation from the arithmetic definition (floor division).
  function automatic logic [7:0] ref_requant(logic signed [31:0] x, int sh, bit relu);
    longint s, t, d, y;
    s = (sh > 31) ? 31 : sh;
    t = longint'(x) + ((s > 0) ? (longint'(1) << (s - 1)) : 0);
    d = longint'(1) << s;
    if (t >= 0) y = t / d;
    else        y = -((-t + d - 1) / d);
    if (relu && y < 0) y = 0;
    if (y > 127)  y = 127;
    if (y < -128) y = -128;
    return y[7:0];
  endfunction

  // Expected event stream of one transfer; stop_row>=0 truncates after that row's read.
  task automatic push_xfer(int rows, int cols, int ob, int ab, int sh, bit relu, bit tr, int stop_row);
    ev_t e;
    logic [DW*M-1:0] row;
    logic [7:0] qv [16];
    e.kind = 2; e.addr = '0; e.en = '0; e.data = '0; e.err = 1'b1;
    if (rows < 1 || rows > N || cols < 1 || cols > M) begin
      exp_q.push_back(e);
      return;
    end
    for (int r = 0; r < rows; r++) begin
      e.kind = 0; e.addr = 10'(ob + r); e.en = '0; e.data = '0; e.err = 1'b0;
      exp_q.push_back(e);
      if (r == stop_row) return;
      row = o_mem[10'(ob + r)];
      for (int c = 0; c < M; c++) qv[c] = ref_requant(row[c*DW +: DW], sh, relu);
      if (!tr) begin
        e.kind = 1; e.addr = 10'(ab + r); e.en = 16'((1 << cols) - 1);
        for (int c = 0; c < M; c++) e.data[c*8 +: 8] = qv[c];
        exp_q.push_back(e);
      end else begin
        for (int c = 0; c < cols; c++) begin
          e.kind = 1; e.addr = 10'(ab + c); e.en = 16'(1) << r; e.data = '0;
          e.data[r*8 +: 8] = qv[c];
          exp_q.push_back(e);
        end
      end
    end
    e.kind = 2; e.addr = '0; e.en = '0; e.data = '0; e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", kind, 99);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    case (kind)
      0: begin
        chk("rd_addr", o_rd_addr, e.addr);
        $display("read  addr=%03h", o_rd_addr);
      end
      1: begin
        chk("wr_addr", a_wr_addr, e.addr);
        chk("wr_en", a_wr_en, e.en);
        chk("wr_data", a_wr_data, e.data);
        $display("write addr=%03h en=%04h data=%032h", a_wr_addr, a_wr_en, a_wr_data);
      end
      default: begin
        chk("done", done, 1);
        chk("err", err, e.err);
        $display("done  err=%0d", err);
      end
    endcase
  endtask

  task automatic drive_cfg(int rows, int cols, int ob, int ab, int sh, bit relu, bit tr);
    num_rows = 5'(rows); num_cols = 5'(cols);
    o_base_addr = 10'(ob); a_base_addr = 10'(ab);
    shift = 5'(sh); relu_en = relu; transpose = tr;
  endtask

  task automatic scramble_cfg();
    drive_cfg($urandom_range(0, 31), $urandom_range(0, 31), $urandom(), $urandom(),
              $urandom(), $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  // Full transfer: push expectations, start, measure done latency and busy time.
  task automatic run_xfer(int rows, int cols, int ob, int ab, int sh, bit relu, bit tr, bit noisy);
    bit legal;
    int n_exp, k, busy_cnt;
    bit got;
    legal = (rows >= 1 && rows <= N && cols >= 1 && cols <= M);
    n_exp = legal ? rows * (1 + RD_LAT + (tr ? cols : 1)) + 1 : 1;
    push_xfer(rows, cols, ob, ab, sh, relu, tr, -1);
    @(negedge clk);
    drive_cfg(rows, cols, ob, ab, sh, relu, tr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    got = 1'b0;
    for (k = 1; k <= 4000; k++) begin
      if (k > 1) @(negedge clk);
      busy_cnt += int'(busy);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (noisy) begin
        scramble_cfg();
        start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    chk("done_cycle", k, n_exp);
    chk("busy_cycles", busy_cnt, legal ? n_exp : 0);
    @(negedge clk);
    chk("idle_after", busy, 0);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_o_rd_en"}, o_rd_en, 0);
    chk({tag, "_o_rd_addr"}, o_rd_addr, 0);
    chk({tag, "_a_wr_en"}, a_wr_en, 0);
    chk({tag, "_a_wr_addr"}, a_wr_addr, 0);
    chk({tag, "_a_wr_data"}, a_wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    logic [31:0] v;
    int base, k;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 1024; a++) begin
      for (int c = 0; c < M; c++) begin
        v = $urandom();
        case ($urandom_range(0, 3))
          0: v = v;
          1: v = 32'($signed(v) >>> 20);
          2: v = 32'($signed(v) >>> 12);
          default: v = 32'($signed(v) >>> 26);
        endcase
        o_mem[a][c*DW +: DW] = v;
      end
    end
    o_mem[10'h010][31:0] = 32'd296;
    o_mem[10'h100][0*DW +: DW] = -32'sd40;
    o_mem[10'h100][1*DW +: DW] = 32'sd5000;
    o_mem[10'h100][2*DW +: DW] = -32'sd5000;
    o_mem[10'h100][3*DW +: DW] = 32'h7FFF_FFFF;
    o_mem[10'h100][4*DW +: DW] = 32'h8000_0000;
    o_mem[10'h201][0*DW +: DW] = 32'd1;
    o_mem[10'h201][1*DW +: DW] = 32'd2;
    o_mem[10'h201][2*DW +: DW] = 32'd3;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (reset === 1'b1) begin
            if (o_rd_en) expect_ev(0);
            if (a_wr_en != '0) begin
              wr_log.push_back(a_wr_data);
              expect_ev(1);
            end
            if (done || err) expect_ev(2);
          end
        end
      end
      begin : stimulus
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // Straight copy, lane0 296 >> 4 rounds to 19.
        base = wr_log.size();
        run_xfer(4, 16, 'h10, 'h20, 4, 0, 0, 0);
        chk("straight_lane0", (wr_log.size() > base) ? wr_log[base][7:0] : 8'hxx, 8'd19);

        // Rounding, saturation and ReLU corner values.
        base = wr_log.size();
        run_xfer(1, 16, 'h100, 'h40, 3, 0, 0, 0);
        chk("round_neg40_s3", (wr_log.size() > base) ? wr_log[base][7:0] : 8'hxx, 8'hFB);
        base = wr_log.size();
        run_xfer(1, 16, 'h100, 'h41, 0, 0, 0, 0);
        chk("sat_pos5000", (wr_log.size() > base) ? wr_log[base][15:8] : 8'hxx, 8'h7F);
        chk("sat_neg5000", (wr_log.size() > base) ? wr_log[base][23:16] : 8'hxx, 8'h80);
        base = wr_log.size();
        run_xfer(1, 16, 'h100, 'h42, 3, 1, 0, 0);
        chk("relu_neg40", (wr_log.size() > base) ? wr_log[base][7:0] : 8'hxx, 8'h00);
        run_xfer(1, 8, 'h100, 'h43, 31, 0, 0, 0);

        // Transposed tile and illegal configurations.
        run_xfer(2, 3, 'h200, 'h50, 0, 0, 1, 0);
        run_xfer(0, 4, 'h000, 'h000, 0, 0, 0, 0);
        run_xfer(4, 17, 'h000, 'h000, 0, 0, 0, 0);
        run_xfer(17, 4, 'h000, 'h000, 0, 0, 1, 0);

        // Read address wraps past the top of the O buffer.
        run_xfer(2, 16, 'h3FF, 'h3FE, 2, 0, 0, 0);

        // Abort while waiting on row 1's read data.
        push_xfer(3, 5, 'h080, 'h090, 1, 0, 0, 1);
        @(negedge clk);
        drive_cfg(3, 5, 'h080, 'h090, 1, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 200; k++) begin
          if (o_rd_en && o_rd_addr == 10'h081) break;
          @(negedge clk);
        end
        chk("abort_reached_row1", k < 200, 1);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", o_rd_en, 0);
        chk("abort_wr_en", a_wr_en, 0);
        chk("abort_done", done, 0);
        repeat (20) @(negedge clk);
        chk("abort_queue_left", exp_q.size(), 0);
        run_xfer(2, 4, 'h0A0, 'h0B0, 2, 1, 1, 0);

        // start and abort together: nothing happens.
        @(negedge clk);
        drive_cfg(2, 4, 'h0C0, 'h0D0, 0, 0, 0);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        repeat (5) @(negedge clk);
        chk("start_abort_queue", exp_q.size(), 0);

        // Randomised transfers with config noise and start pulses while busy.
        for (int t = 0; t < 30; t++) begin
          run_xfer($urandom_range(0, 16), $urandom_range(0, 17), $urandom_range(0, 1023),
                   $urandom_range(0, 1023), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1);
        end

        // Asynchronous reset in the middle of the transposed writes.
        push_xfer(4, 8, 'h300, 'h310, 1, 0, 1, -1);
        @(negedge clk);
        drive_cfg(4, 8, 'h300, 'h310, 1, 0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (k = 0; k < 200; k++) begin
          if (a_wr_en != '0) break;
          @(negedge clk);
        end
        chk("reset_reached_wr", k < 200, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("midreset");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        run_xfer(3, 16, 'h120, 'h130, 5, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/intra_xfer_engine.md
Name: intra_xfer_engine

Overview:
Parametrised successor to the fixed 16x16 O-buffer to A-buffer intra-network path. It moves a num_rows x num_cols tile of 32-bit results from the O buffer into the A buffer without leaving the accelerator, so one layer's output becomes the next layer's activations. On the way it requantises each value (rounding arithmetic right shift, optional ReLU, saturation to ACT_WIDTH). It supports a straight or a transposed write layout, a configurable RAM read latency, and abort.

Parameters:
ARRAY_N, 16, A-buffer bank count / max tile rows
ARRAY_M, 16, O-buffer lane count / max tile cols
ACT_WIDTH, 8, signed activation width written to A
DATA_WIDTH, 32, signed O-buffer lane width
ADDR_WIDTH, 10, O and A buffer address width
RD_LAT, 1, O-buffer read latency in cycles (>=1)
SHIFT_WIDTH, 5, width of requant shift field

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request, sampled only in IDLE
abort  in  1  return to IDLE at next edge; no done
num_rows  in  $clog2(ARRAY_N)+1  tile rows (O rows read)
num_cols  in  $clog2(ARRAY_M)+1  tile cols (lanes per row)
o_base_addr  in  ADDR_WIDTH  first O row address
a_base_addr  in  ADDR_WIDTH  first A address
shift  in  SHIFT_WIDTH  requant right-shift amount
relu_en  in  1  clamp negatives to 0
transpose  in  1  0 straight, 1 transposed layout
o_rd_en  out  1  O-buffer read strobe
o_rd_addr  out  ADDR_WIDTH  O-buffer read address
o_rd_data  in  DATA_WIDTH*ARRAY_M  O row; valid RD_LAT cycles after o_rd_en
a_wr_en  out  ARRAY_N  per-bank A write enables
a_wr_addr  out  ADDR_WIDTH  A write address (shared by banks)
a_wr_data  out  ACT_WIDTH*ARRAY_M  A write data, lane i at [i*ACT_WIDTH +: ACT_WIDTH]
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle illegal-config pulse

Behaviour:
- Reset (reset=0, async): state IDLE, row/col counters 0. All outputs 0: o_rd_en, o_rd_addr, a_wr_en, a_wr_addr, a_wr_data, busy, done, err.
- Configuration is latched on an accepted start. Input changes while busy have no effect. start while busy is ignored.
- Illegal config (num_rows==0, num_rows>ARRAY_N, num_cols==0 or num_cols>ARRAY_M): no reads or writes; err=1 and done=1 together for one cycle; state stays IDLE.
- States: IDLE, RD, WAIT, WR, DONE.
  - IDLE --start ok--> RD.
  - RD: one cycle; o_rd_en=1, o_rd_addr=o_base+r (mod 2^ADDR_WIDTH).
  - WAIT: RD_LAT cycles. At the edge ending the last WAIT cycle, the requantised o_rd_data is registered into q_reg. Then WR.
  - WR (transpose=0): one cycle; a_wr_addr=a_base+r, a_wr_en = (1<<num_cols)-1, a_wr_data=q_reg.
  - WR (transpose=1): num_cols cycles, c=0..num_cols-1; a_wr_addr=a_base+c, a_wr_en=1<<r, lane r of a_wr_data = q_reg lane c, other lanes 0.
  - After WR: if r==num_rows-1 go to DONE, else r+1 and go to RD.
  - DONE: one cycle, done=1, then IDLE.
- Per-row cycles: 1+RD_LAT+(transpose ? num_cols : 1). Busy duration: num_rows*per-row + 1.
- Outside their active states, o_rd_en=0 and a_wr_en=0; address and data hold their last value.
- Requant per lane (signed):
  - s = min(shift, DATA_WIDTH-1).
  - t = x + (s>0 ? 1<<(s-1) : 0), computed in DATA_WIDTH+1 bits (no overflow).
  - y = t >>> s (floor).
  - If relu_en and y<0, y=0.
  - Saturate y to [-2^(ACT_WIDTH-1), 2^(ACT_WIDTH-1)-1].
- Address wrap: base+offset wraps modulo 2^ADDR_WIDTH silently.
- abort, any state: next edge goes to IDLE; that edge clears o_rd_en and a_wr_en; no done and no err. Writes already issued are not undone.
- abort and start in the same IDLE cycle: abort wins, no transfer.
- reset mid-transfer: immediate IDLE with all outputs 0.

Decomposition:
- Shared header/package: state encodings (IDLE, RD, WAIT, WR, DONE), the requant rounding/saturation constants, and a localparam for the CNT width $clog2(ARRAY_N)+1, shared with the existing A/O buffer blocks.
- One natural sub-module: requant_lane (combinational, DATA_WIDTH in, ACT_WIDTH out, shift, relu_en), instantiated ARRAY_M times. The top holds the FSM, counters and q_reg.

Test Plan:
- Straight copy, RD_LAT=1, rows=4, cols=16, shift=4, o_base=0x10, a_base=0x20; lane0 of row0 = 296 -> A[0x20] lane0 = 19. Four writes at 0x20..0x23, all enables 0xFFFF; done on cycle 13 after start; busy for 13 cycles.
- Rounding and saturation, shift=3: -40 -> -5 (0xFB). shift=0: 5000 -> 127 and -5000 -> -128 (0x80). relu_en=1: -40 -> 0.
- Transpose, rows=2, cols=3: O row1 lanes {1,2,3}, shift=0 -> three writes to addresses a_base+0..2 with a_wr_en=0x0002 and lane1 data = 1,2,3. Row takes 1+RD_LAT+3 cycles.
- Illegal config: num_rows=0 or num_cols=17 -> err and done pulse together the next cycle; no o_rd_en or a_wr_en ever asserted; busy stays 0.
- Wrap and latency: RD_LAT=3, o_base=0x3FF, rows=2 -> reads at 0x3FF then 0x000; data captured exactly 3 cycles after each o_rd_en.
- abort asserted in the WAIT state of row 1 -> IDLE next cycle, no further writes, done never pulses. A new start is then accepted normally. reset asserted mid-WR clears all outputs asynchronously.
